// File: rtl/snn_pkg.sv
// Shared types and helpers for the spiking-network blocks: synapse FSM states,
// default datapath width and a width-generic saturating adder.
package snn_pkg;

    localparam int WIDTH = 16;
    localparam logic [WIDTH-1:0] SAT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READY,
        S_REFRACT
    } syn_state_t;

    // Unsigned a + b clamped to 2^w - 1. Valid for w in 1..32.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int unsigned w);
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << w) - 33'd1;
        return (sum > lim) ? lim[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/synapse_decay_step.sv
// One step of exponential decay: acc - (acc >> k), with a minimum decrement of
// 1 so a non-zero accumulator always drains to exactly zero.
module synapse_decay_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_acc,
    input  logic [3:0]       i_k,
    output logic [WIDTH-1:0] o_acc_d
);

    logic [WIDTH-1:0] w_dec;

    // NOTE: every variable written here gets a value on every path first, so
    // no latch is inferred.
    always_comb begin
        w_dec = i_acc >> i_k;
        if (i_acc != '0 && w_dec == '0) begin
            w_dec = WIDTH'(1);
        end
        o_acc_d = i_acc - w_dec;
    end

endmodule

// File: rtl/spike_synapse.sv
// Spike-to-current synapse: accepted rising edges add a weight to a decaying
// accumulator; a refractory window drops closely spaced edges; ISI and count
// are reported for rate decoding.
module spike_synapse #(
    parameter int WIDTH          = snn_pkg::WIDTH,
    parameter int REFRACT_CYCLES = 4,
    parameter int COUNT_W        = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               spike_in,
    input  logic [WIDTH-1:0]   weight,
    input  logic [3:0]         decay_shift,
    output logic [WIDTH-1:0]   current_out,
    output logic [WIDTH-1:0]   isi_out,
    output logic               isi_valid,
    output logic [COUNT_W-1:0] spike_count,
    output logic               refractory
);

    import snn_pkg::*;

    localparam logic [7:0] REFR_LAST = 8'(REFRACT_CYCLES - 1);

    syn_state_t         r_state;
    syn_state_t         w_state_next;
    logic               r_spike_d;
    logic [7:0]         r_refr_cnt;
    logic [WIDTH-1:0]   r_isi_cnt;
    logic [WIDTH-1:0]   r_isi_out;
    logic               r_isi_valid;
    logic [WIDTH-1:0]   r_acc;
    logic [COUNT_W-1:0] r_count;

    logic               w_edge;
    logic               w_accept;
    logic               w_refr_done;
    logic [WIDTH-1:0]   w_acc_d;

    assign w_edge      = spike_in & ~r_spike_d;
    assign w_refr_done = (r_state == S_REFRACT) && (r_refr_cnt == REFR_LAST);

    synapse_decay_step #(.WIDTH(WIDTH)) u_decay (
        .i_acc   (r_acc),
        .i_k     (decay_shift),
        .o_acc_d (w_acc_d)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // An edge in the last refractory cycle is still dropped.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE, S_READY: begin
                if (w_edge) begin
                    w_accept     = 1'b1;
                    w_state_next = S_REFRACT;
                end
            end
            S_REFRACT: begin
                if (w_refr_done) begin
                    w_state_next = S_READY;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_spike_d   <= 1'b0;
            r_refr_cnt  <= '0;
            r_isi_cnt   <= '0;
            r_isi_out   <= '0;
            r_isi_valid <= 1'b0;
            r_acc       <= '0;
            r_count     <= '0;
        end else begin
            r_spike_d   <= spike_in;
            r_isi_valid <= w_accept && (r_state == S_READY);

            if (w_accept) begin
                r_refr_cnt <= '0;
            end else if (r_state == S_REFRACT) begin
                r_refr_cnt <= w_refr_done ? 8'd0 : r_refr_cnt + 8'd1;
            end

            if (w_accept) begin
                r_isi_cnt <= WIDTH'(1);
                r_count   <= COUNT_W'(sat_add(32'(r_count), 32'd1, COUNT_W));
                // Decay first, then add the weight with saturation.
                r_acc     <= WIDTH'(sat_add(32'(w_acc_d), 32'(weight), WIDTH));
                if (r_state == S_READY) begin
                    r_isi_out <= r_isi_cnt;
                end
            end else begin
                r_isi_cnt <= WIDTH'(sat_add(32'(r_isi_cnt), 32'd1, WIDTH));
                r_acc     <= w_acc_d;
            end
        end
    end

    assign current_out = r_acc;
    assign isi_out     = r_isi_out;
    assign isi_valid   = r_isi_valid;
    assign spike_count = r_count;
    assign refractory  = (r_state == S_REFRACT);

endmodule
